irq_entry_ctrl: RTL
===================

// Module: irq_entry_ctrl
// PURPOSE
//  Sequences asynchronous interrupt entry for the 5-stage core (IF, ID, EX, MEM1, MEM2/WB).
//  On an enabled pending IRQ it stalls fetch and lets the in-flight instructions drain.
//  When the pipeline is empty it issues a one-cycle trap request to fetch and cs_registers.
//  It sits beside the hazard controller, which ORs its stall/flush outputs into its own.
// PARAMETERS
//  DRAIN_MAX = 64 : drain cycles before drain_timeout_o is raised (debug only, no abort)
//  CNT_W     = 32 : width of the taken-interrupt counter
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          synchronous reset, active-high
//  irq_pending_i    in   irqs_t     pending & enabled-in-mie IRQs {m_software, m_timer, m_external}
//  mstatus_mie_i    in   1          global M-mode interrupt enable
//  current_plvl_i   in   priv_lvl_e current privilege level
//  instr_valid_i    in   5          valid bits [0]=IF/ID .. [4]=MEM2/WB
//  mem_trap_i       in   1          a synchronous trap/MRET is being taken this cycle
//  fetch_pc_i       in   32         PC of the next instruction fetch will issue
//  fetch_stall_o    out  1          hold fetch PC, issue no new request
//  if_id_flush_o    out  1          squash IF/ID; its PC is already held in fetch_pc_i
//  new_pc_en_o      out  1          redirect fetch to PC_TRAP (pulse)
//  is_trap_o        out  1          cs_registers: save mepc/mcause, clear MIE (pulse)
//  csr_mcause_o     out  mcause_t   {irq=1, trap_code}; valid when is_trap_o is high
//  exc_pc_o         out  32         value for mepc; valid when is_trap_o is high
//  busy_o           out  1          FSM is not in IDLE
//  drain_timeout_o  out  1          sticky; set when drain exceeds DRAIN_MAX
//  irq_count_o      out  CNT_W      number of interrupts taken, wraps on overflow
// BEHAVIOUR
//  - Reset: FSM to IDLE. All outputs 0; counters 0; drain_timeout_o cleared.
//  - Enable: irq_en = mstatus_mie_i || current_plvl_i==PRIV_LVL_U.
//    take_req = irq_en && |irq_pending_i.
//  - Priority: m_external (code 11) > m_software (3) > m_timer (7).
//  - IDLE: on take_req && !mem_trap_i, go to DRAIN; the drain counter clears.
//    When mem_trap_i is high, the synchronous trap wins and the FSM stays in IDLE.
//  - DRAIN: fetch_stall_o=1 and if_id_flush_o=1 combinationally while in this state.
//    * mem_trap_i=1: go to IDLE. The trap handler clears MIE; pending IRQs are re-evaluated later.
//    * !take_req (IRQ dropped or disabled): go to IDLE and release the stall, no trap.
//    * instr_valid_i==0 (pipeline empty): go to TAKE.
//    * The drain counter saturates at DRAIN_MAX and sets drain_timeout_o when it reaches it.
//  - TAKE (exactly 1 cycle):
//    * new_pc_en_o=1, is_trap_o=1, fetch_stall_o=1.
//    * Priority is re-encoded from the current irq_pending_i.
//    * csr_mcause_o={1'b1, code}; exc_pc_o=fetch_pc_i.
//    * If take_req dropped in this same cycle, TAKE still uses the last registered code.
//      The code register is updated every DRAIN cycle.
//    * irq_count_o increments. Next state is COOL.
//  - COOL (1 cycle): fetch_stall_o=0. Lets the MIE=0 CSR write settle.
//    take_req is ignored in COOL, which prevents a double entry. Next state is IDLE.
//  - Latency: from take_req rising with an empty pipeline, is_trap_o is high 2 cycles later.
//    Worst case adds the drain time (≤5 cycles plus any LSU stalls).
//  - Outputs new_pc_en_o and is_trap_o are never high outside TAKE.
//  - Reset asserted in any state: IDLE on the next edge, no trap pulse.
// STRUCTURE
//  - Shared package (csr_pkg/riscv_pkg) holds:
//    * the state enum irq_state_e {IDLE, DRAIN, TAKE, COOL};
//    * the CSR_MEI/MSI/MTI_BIT codes;
//    * irqs_t, mcause_t, priv_lvl_e.
//  - One sub-module: irq_prio_enc (combinational irqs_t -> {valid, code[3:0]}).
//    It is reusable by the CLINT/CSR.
//  - Single FSM always_ff plus an always_comb output decode. No latches; all registers use sync reset.
// TESTING
//  - Empty pipe, MIE=1, m_timer pulse:
//    DRAIN 1 cycle, then TAKE with mcause={1,7}, exc_pc=fetch_pc_i, irq_count_o=1.
//  - m_external+m_timer together with 3 valid instrs draining over 3 cycles:
//    stall held 3 cycles, then mcause code 11, exactly one is_trap_o pulse.
//  - mem_trap_i asserted on the 2nd DRAIN cycle:
//    back to IDLE next cycle, no is_trap_o, fetch_stall_o low.
//  - MIE=0 in M-mode with m_software pending: FSM stays IDLE.
//    Same stimulus with PRIV_LVL_U: TAKE with code 3.
//  - IRQ deasserted mid-DRAIN: IDLE, no trap.
//    Separately, instr_valid_i stuck at 5'b10000 for 70 cycles: drain_timeout_o=1 at cycle 64.
//  - rst_i asserted during DRAIN: all outputs 0 on the next cycle, counter 0, FSM IDLE.

Source files
------------

// File: rtl/irq_entry_ctrl_pkg.sv
// Shared types for interrupt entry: FSM states, privilege levels, IRQ vector and mcause layout.
package irq_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2,
    COOL  = 2'd3
  } irq_state_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  localparam logic [3:0] CSR_MSI_BIT = 4'd3;
  localparam logic [3:0] CSR_MTI_BIT = 4'd7;
  localparam logic [3:0] CSR_MEI_BIT = 4'd11;

  typedef struct packed {
    logic m_software;
    logic m_timer;
    logic m_external;
  } irqs_t;

  typedef struct packed {
    logic       irq;
    logic [3:0] trap_code;
  } mcause_t;

endpackage

// File: rtl/irq_entry_ctrl_if.sv
// Pipeline/CSR-side signal bundle of the interrupt entry controller.
interface irq_entry_ctrl_if
  import irq_entry_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  irqs_t            irq_pending_i;
  logic             mstatus_mie_i;
  priv_lvl_e        current_plvl_i;
  logic [4:0]       instr_valid_i;
  logic             mem_trap_i;
  logic [31:0]      fetch_pc_i;
  logic             fetch_stall_o;
  logic             if_id_flush_o;
  logic             new_pc_en_o;
  logic             is_trap_o;
  mcause_t          csr_mcause_o;
  logic [31:0]      exc_pc_o;
  logic             busy_o;
  logic             drain_timeout_o;
  logic [CNT_W-1:0] irq_count_o;

  modport slave (
    input  irq_pending_i, mstatus_mie_i, current_plvl_i, instr_valid_i,
           mem_trap_i, fetch_pc_i,
    output fetch_stall_o, if_id_flush_o, new_pc_en_o, is_trap_o,
           csr_mcause_o, exc_pc_o, busy_o, drain_timeout_o, irq_count_o
  );

  modport master (
    output irq_pending_i, mstatus_mie_i, current_plvl_i, instr_valid_i,
           mem_trap_i, fetch_pc_i,
    input  fetch_stall_o, if_id_flush_o, new_pc_en_o, is_trap_o,
           csr_mcause_o, exc_pc_o, busy_o, drain_timeout_o, irq_count_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: external > software > timer.
module irq_prio_enc
  import irq_entry_ctrl_pkg::*;
(
  input  irqs_t      irqs,
  output logic       valid,
  output logic [3:0] code
);

  always_comb begin
    valid = irqs.m_external | irqs.m_software | irqs.m_timer;
    code  = '0;
    if (irqs.m_external) begin
      code = CSR_MEI_BIT;
    end else if (irqs.m_software) begin
      code = CSR_MSI_BIT;
    end else if (irqs.m_timer) begin
      code = CSR_MTI_BIT;
    end
  end

endmodule

// File: rtl/irq_entry_ctrl.sv
// Interrupt entry sequencer: stalls fetch, drains the pipe, then issues a one-cycle trap request.
module irq_entry_ctrl
  import irq_entry_ctrl_pkg::*;
#(
  parameter int DRAIN_MAX = 64,
  parameter int CNT_W     = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  irq_entry_ctrl_if.slave bus
);

  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [DCNT_W-1:0] DRAIN_TOP  = DCNT_W'(DRAIN_MAX);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

  irq_state_e        state_reg;
  logic [DCNT_W-1:0] drain_cnt_reg;
  logic              timeout_reg;
  logic [3:0]        code_reg;
  logic [CNT_W-1:0]  count_reg;

  logic       irq_en;
  logic       prio_valid;
  logic [3:0] prio_code;
  logic       take_req;

  irq_prio_enc u_prio_enc (
    .irqs  (bus.irq_pending_i),
    .valid (prio_valid),
    .code  (prio_code)
  );

  // User mode is always interruptible by M-mode sources regardless of MIE.
  assign irq_en   = bus.mstatus_mie_i || (bus.current_plvl_i == PRIV_LVL_U);
  assign take_req = irq_en && prio_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
      code_reg      <= '0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          drain_cnt_reg <= '0;
          if (take_req && !bus.mem_trap_i) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (prio_valid) begin
            code_reg <= prio_code;
          end
          if (drain_cnt_reg != DRAIN_TOP) begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
          if (drain_cnt_reg == DRAIN_LAST) begin
            timeout_reg <= 1'b1;
          end
          if (bus.mem_trap_i || !take_req) begin
            state_reg <= IDLE;
          end else if (bus.instr_valid_i == 5'b0) begin
            state_reg <= TAKE;
          end
        end
        TAKE: begin
          count_reg <= count_reg + 1'b1;
          state_reg <= COOL;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  logic        stall_dec;
  logic        flush_dec;
  logic        trap_dec;
  mcause_t     mcause_dec;
  logic [31:0] exc_pc_dec;

  always_comb begin
    stall_dec  = 1'b0;
    flush_dec  = 1'b0;
    trap_dec   = 1'b0;
    mcause_dec = '0;
    exc_pc_dec = '0;
    case (state_reg)
      DRAIN: begin
        stall_dec = 1'b1;
        flush_dec = 1'b1;
      end
      TAKE: begin
        stall_dec  = 1'b1;
        trap_dec   = 1'b1;
        // A request that vanished in this very cycle falls back to the code seen while draining.
        mcause_dec = mcause_t'({1'b1, take_req ? prio_code : code_reg});
        exc_pc_dec = bus.fetch_pc_i;
      end
      default: begin
      end
    endcase
  end

  assign bus.fetch_stall_o   = stall_dec;
  assign bus.if_id_flush_o   = flush_dec;
  assign bus.new_pc_en_o     = trap_dec;
  assign bus.is_trap_o       = trap_dec;
  assign bus.csr_mcause_o    = mcause_dec;
  assign bus.exc_pc_o        = exc_pc_dec;
  assign bus.busy_o          = (state_reg != IDLE);
  assign bus.drain_timeout_o = timeout_reg;
  assign bus.irq_count_o     = count_reg;

endmodule
